// File: rtl/l1_cache_pkg.sv
// Shared types for the L1 cache: address fields, line type and controller states.
package l1_cache_pkg;

  localparam int OFFSET_BITS  = 4;
  localparam int SET_BITS_DEF = 3;

  typedef logic [15:0]                  lc3b_word;
  typedef logic [1:0]                   lc3b_mem_wmask;
  typedef logic [11-SET_BITS_DEF:0]     lc3b_c_tag;
  typedef logic [SET_BITS_DEF-1:0]      lc3b_c_index;
  typedef logic [OFFSET_BITS-1:0]       lc3b_c_offset;
  typedef logic [127:0]                 lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

endpackage

// File: rtl/l1_cache_array.sv
// One field of per-set cache storage: flop array, async read, sync write, reset to zero.
module cache_array #(
  parameter int WIDTH    = 1,
  parameter int SET_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SET_BITS-1:0] index,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout
);

  logic [WIDTH-1:0] entry_q [2**SET_BITS];

  // Clear every entry on reset, otherwise write the indexed entry on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**SET_BITS; i++) entry_q[i] <= '0;
    end else if (load) begin
      entry_q[index] <= din;
    end
  end

  assign dout = entry_q[index];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back write-allocate L1 cache: 16-bit CPU words, 128-bit pmem lines.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int SET_BITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_c_line    pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_c_line    pmem_rdata
);

  localparam int TAG_BITS = 12 - SET_BITS;

  cache_state_t state_q;

  logic [TAG_BITS-1:0] addr_tag;
  logic [SET_BITS-1:0] addr_set;
  logic [2:0]          addr_word;
  logic                addr_unused;

  assign addr_tag    = mem_address[15:4+SET_BITS];
  assign addr_set    = mem_address[3+SET_BITS:4];
  assign addr_word   = mem_address[3:1];
  assign addr_unused = mem_address[0];

  lc3b_c_line          line_rd, line_merged, data_din;
  logic [TAG_BITS-1:0] tag_rd;
  logic                valid_rd, dirty_rd;
  logic                req, hit, wr_hit_upd, fill_done, wb_done;
  logic                data_load, dirty_load;

  assign req        = mem_read | mem_write;
  assign hit        = (state_q == IDLE) && req && valid_rd && (tag_rd == addr_tag);
  assign wr_hit_upd = hit && mem_write && (|mem_byte_enable);
  assign fill_done  = (state_q == ALLOCATE) && pmem_resp;
  assign wb_done    = (state_q == WRITEBACK) && pmem_resp;
  assign data_load  = wr_hit_upd | fill_done;
  assign dirty_load = wr_hit_upd | wb_done | fill_done;
  assign data_din   = fill_done ? pmem_rdata : line_merged;

  // Byte merge: only the selected word's enabled bytes take the CPU write data.
  for (genvar gi = 0; gi < 8; gi++) begin : g_merge
    assign line_merged[16*gi+7 -: 8] =
      ((addr_word == 3'(gi)) && mem_byte_enable[0]) ? mem_wdata[7:0]  : line_rd[16*gi+7 -: 8];
    assign line_merged[16*gi+15 -: 8] =
      ((addr_word == 3'(gi)) && mem_byte_enable[1]) ? mem_wdata[15:8] : line_rd[16*gi+15 -: 8];
  end

  cache_array #(.WIDTH(128), .SET_BITS(SET_BITS)) u_data (
    .clk(clk), .reset(reset), .load(data_load), .index(addr_set), .din(data_din), .dout(line_rd));
  cache_array #(.WIDTH(TAG_BITS), .SET_BITS(SET_BITS)) u_tag (
    .clk(clk), .reset(reset), .load(fill_done), .index(addr_set), .din(addr_tag), .dout(tag_rd));
  cache_array #(.WIDTH(1), .SET_BITS(SET_BITS)) u_valid (
    .clk(clk), .reset(reset), .load(fill_done), .index(addr_set), .din(1'b1), .dout(valid_rd));
  cache_array #(.WIDTH(1), .SET_BITS(SET_BITS)) u_dirty (
    .clk(clk), .reset(reset), .load(dirty_load), .index(addr_set), .din(wr_hit_upd), .dout(dirty_rd));

  // Controller: misses evict a dirty victim first, then fill; fills return to IDLE to hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:      if (req && !hit) state_q <= (valid_rd && dirty_rd) ? WRITEBACK : ALLOCATE;
        WRITEBACK: if (pmem_resp) state_q <= ALLOCATE;
        ALLOCATE:  if (pmem_resp) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Output decode: CPU response only on an IDLE hit, pmem side purely from state.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        mem_resp  = hit;
        mem_rdata = (hit && mem_read) ? line_rd[{addr_word, 4'b0000} +: 16] : '0;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_rd, addr_set, lc3b_c_offset'(0)};
        pmem_wdata   = line_rd;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], lc3b_c_offset'(0)};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed vector table, corner sequences, random mix vs flat memory.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata));

  logic [127:0] pmem_lines [4096];
  logic [7:0]   ref_mem    [65536];

  int n_tests = 0, n_fail = 0;
  int fills = 0, wbs = 0;
  int pmem_fixed_lat = 0;
  bit pmem_stall = 1'b0;
  int overlap_err = 0, resp_busy_err = 0, align_err = 0;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } pmem_txn_t;
  pmem_txn_t plog[$];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    bit          chk_rd;
    logic [15:0] exp_rd;
    int          exp_fills;
    int          exp_wbs;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pset_word(input int a, input logic [15:0] v);
    pmem_lines[a >> 4][8*(a & 15) +: 16] = v;
  endtask

  task automatic sync_ref_from_pmem();
    for (int a = 0; a < 65536; a++) ref_mem[a] = pmem_lines[a >> 4][8*(a & 15) +: 8];
  endtask

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    return {ref_mem[a | 16'h0001], ref_mem[a & 16'hFFFE]};
  endfunction

  // Physical memory: after a latency, serve the request held on the pmem port.
  initial begin
    int cnt, lat;
    cnt = 0; lat = 1;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if ((pmem_read || pmem_write) && !pmem_stall && !reset) begin
        if (cnt == 0) lat = (pmem_fixed_lat > 0) ? pmem_fixed_lat : int'($urandom_range(1, 20));
        cnt++;
        if (cnt >= lat) begin
          if (pmem_address[3:0] != 4'h0) align_err++;
          if (pmem_write) begin
            pmem_lines[pmem_address[15:4]] = pmem_wdata;
            wbs++;
            plog.push_back('{1'b1, pmem_address, pmem_wdata});
          end else begin
            pmem_rdata = pmem_lines[pmem_address[15:4]];
            fills++;
            plog.push_back('{1'b0, pmem_address, pmem_rdata});
          end
          pmem_resp = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Protocol watch: pmem read/write exclusive, no CPU response while pmem busy.
  always @(negedge clk) begin
    if (pmem_read && pmem_write) overlap_err++;
    if (mem_resp && (pmem_read || pmem_write)) resp_busy_err++;
    assert (!(mem_read && mem_write)) else $error("bench drove read and write together");
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One CPU transaction; called at posedge+2, returns at posedge+2 with request dropped.
  task automatic access(input bit wr, input logic [15:0] a, input logic [1:0] b,
                        input logic [15:0] wd, output logic [15:0] rd, output int waits);
    mem_address = a; mem_byte_enable = b; mem_wdata = wd;
    mem_read = !wr; mem_write = wr;
    waits = 0; rd = 'x;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        rd = mem_rdata;
        break;
      end
      waits++;
    end
    if (waits >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout: addr %0h got no mem_resp, required one within 400 cycles", a);
    end
    @(posedge clk); #2;
    mem_read = 1'b0; mem_write = 1'b0;
    if (wr && waits < 400) begin
      if (b[0]) ref_mem[a & 16'hFFFE] = wd[7:0];
      if (b[1]) ref_mem[a | 16'h0001] = wd[15:8];
    end
  endtask

  initial begin
    logic [15:0]  rd, exp;
    logic [127:0] exp_line;
    int           waits, f0, w0;
    bit           wr;
    logic [15:0]  a, wd;
    logic [1:0]   b;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_address = '0; mem_wdata = '0;

    for (int l = 0; l < 4096; l++) pmem_lines[l] = {$urandom, $urandom, $urandom, $urandom};
    pset_word(16'h1230, 16'h1111);
    pset_word(16'h1232, 16'h5678);
    pset_word(16'h1236, 16'hAAAA);
    pset_word(16'h1238, 16'hBBBB);
    pset_word(16'h2230, 16'h2222);
    sync_ref_from_pmem();

    // Reset, then every output must be quiet.
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset mem_resp", mem_resp, 1'b0);
    check("reset mem_rdata", mem_rdata, 16'h0);
    check("reset pmem_read", pmem_read, 1'b0);
    check("reset pmem_write", pmem_write, 1'b0);
    check("reset pmem_address", pmem_address, 16'h0);
    check("reset pmem_wdata", pmem_wdata, 128'h0);
    @(posedge clk); #2;

    // Directed table: cold miss, hit, byte writes, dirty and clean conflicts in set 3.
    vecs[0]  = '{1'b0, 16'h1236, 2'b11, 16'h0000, 1'b1, 16'hAAAA, 1, 0};
    vecs[1]  = '{1'b0, 16'h1230, 2'b11, 16'h0000, 1'b1, 16'h1111, 0, 0};
    vecs[2]  = '{1'b1, 16'h1232, 2'b01, 16'hABCD, 1'b0, 16'h0000, 0, 0};
    vecs[3]  = '{1'b0, 16'h1232, 2'b11, 16'h0000, 1'b1, 16'h56CD, 0, 0};
    vecs[4]  = '{1'b0, 16'h2230, 2'b11, 16'h0000, 1'b1, 16'h2222, 1, 1};
    vecs[5]  = '{1'b0, 16'h1232, 2'b11, 16'h0000, 1'b1, 16'h56CD, 1, 0};
    vecs[6]  = '{1'b1, 16'h1230, 2'b00, 16'hFFFF, 1'b0, 16'h0000, 0, 0};
    vecs[7]  = '{1'b0, 16'h1230, 2'b11, 16'h0000, 1'b1, 16'h1111, 0, 0};
    vecs[8]  = '{1'b0, 16'h2230, 2'b11, 16'h0000, 1'b1, 16'h2222, 1, 0};
    vecs[9]  = '{1'b1, 16'h2230, 2'b10, 16'h9900, 1'b0, 16'h0000, 0, 0};
    vecs[10] = '{1'b0, 16'h2230, 2'b11, 16'h0000, 1'b1, 16'h9922, 0, 0};
    vecs[11] = '{1'b0, 16'h1230, 2'b11, 16'h0000, 1'b1, 16'h1111, 1, 1};

    for (int v = 0; v < 12; v++) begin
      f0 = fills; w0 = wbs;
      access(vecs[v].wr, vecs[v].addr, vecs[v].be, vecs[v].wdata, rd, waits);
      if (vecs[v].chk_rd) check($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d fills", v), fills - f0, vecs[v].exp_fills);
      check($sformatf("vec%0d writebacks", v), wbs - w0, vecs[v].exp_wbs);
      $display("[TB] vec%0d %s addr=%04h be=%b rd=%04h fills+%0d wbs+%0d",
               v, vecs[v].wr ? "W" : "R", vecs[v].addr, vecs[v].be, rd, fills - f0, wbs - w0);
    end

    // Dirty conflict order: writeback of the modified 0x1230 line, then fill of 0x2230.
    if (plog.size() >= 3) begin
      check("conflict wb is write", plog[1].wr, 1'b1);
      check("conflict wb address", plog[1].addr, 16'h1230);
      check("conflict wb word1", plog[1].data[31:16], 16'h56CD);
      check("conflict wb word0", plog[1].data[15:0], 16'h1111);
      check("conflict fill is read", plog[2].wr, 1'b0);
      check("conflict fill address", plog[2].addr, 16'h2230);
    end else begin
      check("conflict log length", plog.size(), 3);
    end

    // Clean-miss latency with fixed pmem delay: wait cycles = delay + 1.
    pmem_fixed_lat = 5;
    f0 = fills; w0 = wbs;
    access(1'b0, 16'h3230, 2'b11, 16'h0, rd, waits);
    check("lat5 wait cycles", waits, 6);
    check("lat5 rdata", rd, ref_word(16'h3230));
    check("lat5 no writeback", wbs - w0, 0);
    $display("[TB] latency delay=5 waits=%0d rd=%04h", waits, rd);
    pmem_fixed_lat = 1;
    access(1'b0, 16'h3240, 2'b11, 16'h0, rd, waits);
    check("lat1 wait cycles", waits, 2);
    check("lat1 rdata", rd, ref_word(16'h3240));
    $display("[TB] latency delay=1 waits=%0d rd=%04h", waits, rd);
    pmem_fixed_lat = 0;

    // Reset during a stalled fill: pmem_read drops next cycle, cached lines are gone.
    pmem_stall = 1'b1;
    mem_address = 16'h4230; mem_byte_enable = 2'b11; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    check("stall pmem_read", pmem_read, 1'b1);
    check("stall pmem_address", pmem_address, 16'h4230);
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midmiss reset pmem_read", pmem_read, 1'b0);
    check("midmiss reset pmem_write", pmem_write, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0; pmem_stall = 1'b0;
    sync_ref_from_pmem();
    f0 = fills;
    access(1'b0, 16'h3230, 2'b11, 16'h0, rd, waits);
    check("post reset refill", fills - f0, 1);
    check("post reset rdata", rd, ref_word(16'h3230));
    $display("[TB] reset mid-miss, reread 3230 fills+%0d rd=%04h", fills - f0, rd);

    // Random mix against the flat reference memory, random pmem latency.
    for (int t = 0; t < 400; t++) begin
      a  = 16'($urandom_range(0, 16'h0FFF));
      wr = 1'($urandom_range(0, 1));
      b  = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      exp = ref_word(a);
      access(wr, a, b, wd, rd, waits);
      if (!wr) check($sformatf("rand%0d rdata @%04h", t, a), rd, exp);
      $display("[TB] rand%0d %s addr=%04h be=%b wd=%04h rd=%04h waits=%0d",
               t, wr ? "W" : "R", a, b, wd, rd, waits);
    end

    // Flush: evict every set with an unused tag, then pmem must equal the reference.
    for (int s = 0; s < 8; s++) begin
      access(1'b0, 16'hF000 | 16'(s << 4), 2'b11, 16'h0, rd, waits);
      $display("[TB] flush set %0d", s);
    end
    for (int l = 0; l < 256; l++) begin
      for (int k = 0; k < 16; k++) exp_line[8*k +: 8] = ref_mem[l*16 + k];
      check($sformatf("flush line %03h", l), pmem_lines[l], exp_line);
    end

    check("pmem read/write overlap", overlap_err, 0);
    check("mem_resp while pmem busy", resp_busy_err, 0);
    check("pmem address alignment", align_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
